// File: rtl/fp_add_pkg.sv
// fp_add_pkg: binary16 field widths, special encodings and field struct shared by the adder
package fp_add_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS = 15;
  localparam int EXP_MAX = 31;
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;
endpackage

// File: rtl/fp_add_lzc.sv
// fp_lzc: leading-zero count of a 14-bit significand (v in, lz out, 14 when v is zero)
module fp_lzc (
  input  logic [13:0] v,
  output logic [3:0]  lz
);
  always_comb begin
    lz = 4'd14;
    for (int i = 0; i < 14; i++) if (v[i]) lz = 4'(13 - i);
  end
endmodule

// File: rtl/floating_point_add.sv
// floating_point_add: 1-cycle RNE binary16 adder (clk, rst; s_axis_a/b tvalid+tdata in; m_axis_result tvalid+tdata out); FP_ADD_SUBNORMAL_EN enables gradual underflow, otherwise subnormals flush to zero
module floating_point_add
  import fp_add_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_a_tvalid,
  input  logic [15:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  input  logic [15:0] s_axis_b_tdata,
  output logic        m_axis_result_tvalid,
  output logic [15:0] m_axis_result_tdata
);
  fp16_t a, b;
  logic a_nan, b_nan, a_inf, b_inf, nan, inf, a_big, sub, sl, up, hid, tiny;
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic [MAN_W:0] ma, mb, ml, ms;
  logic [23:0] wide;
  logic [13:0] xl, xs, v, vn;
  logic [14:0] sum;
  logic [3:0] lz;
  logic [6:0] en, sh, eo, ef;
  logic [11:0] mr;
  logic [15:0] res;
  assign a = s_axis_a_tdata;
  assign b = s_axis_b_tdata;
  assign a_nan = &a.exp & |a.man;
  assign b_nan = &b.exp & |b.man;
  assign a_inf = &a.exp & ~|a.man;
  assign b_inf = &b.exp & ~|b.man;
  assign nan = a_nan | b_nan | (a_inf & b_inf & (a.sign ^ b.sign));
  assign inf = a_inf | b_inf;
  assign ea = |a.exp ? a.exp : 5'd1;
  assign eb = |b.exp ? b.exp : 5'd1;
`ifdef FP_ADD_SUBNORMAL_EN
  assign ma = {|a.exp, a.man};
  assign mb = {|b.exp, b.man};
  assign tiny = 1'b0;
`else
  assign ma = |a.exp ? {1'b1, a.man} : '0;
  assign mb = |b.exp ? {1'b1, b.man} : '0;
  assign tiny = ~hid;
`endif
  assign a_big = {ea, ma} >= {eb, mb};
  assign el = a_big ? ea : eb;
  assign es = a_big ? eb : ea;
  assign ml = a_big ? ma : mb;
  assign ms = a_big ? mb : ma;
  assign sl = a_big ? a.sign : b.sign;
  assign sub = a.sign ^ b.sign;
  assign d = el - es;
  // 11-bit significand + guard/round/sticky; the far operand survives only as sticky
  assign wide = {ms, 13'b0} >> d;
  assign xs = d >= 5'd13 ? {13'b0, |ms} : {wide[23:11], |wide[10:0]};
  assign xl = {ml, 3'b0};
  assign sum = sub ? {1'b0, xl} - {1'b0, xs} : {1'b0, xl} + {1'b0, xs};
  assign v = sum[14] ? {sum[14:2], |sum[1:0]} : sum[13:0];
  assign en = {2'b0, el} + {6'b0, sum[14]};
  fp_lzc u_lzc (.v(v), .lz(lz));
  // stop the left shift at exponent 1 so results below 2^-14 land in subnormal form
  assign sh = {3'b0, lz} <= en - 7'd1 ? {3'b0, lz} : en - 7'd1;
  assign eo = en - sh;
  assign vn = v << sh;
  assign up = vn[2] & (|vn[1:0] | vn[3]);
  assign mr = {1'b0, vn[13:3]} + {11'b0, up};
  assign hid = mr[11] | mr[10];
  assign ef = eo + {6'b0, mr[11]};
  assign res = nan ? QNAN
             : inf ? ((a_inf ? a.sign : b.sign) ? NEG_INF : POS_INF)
             : ~|v ? {a.sign & b.sign, 15'b0}
             : ef >= 7'(EXP_MAX) ? (sl ? NEG_INF : POS_INF)
             : tiny ? {sl, 15'b0}
             : {sl, hid ? ef[4:0] : 5'b0, mr[9:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata <= 16'h0000;
    end else begin
      m_axis_result_tvalid <= s_axis_a_tvalid & s_axis_b_tvalid;
      if (s_axis_a_tvalid & s_axis_b_tvalid) m_axis_result_tdata <= res;
    end
  end
endmodule

// File: tb/tb_floating_point_add.sv
// tb_floating_point_add: directed and randomized checks of floating_point_add against a real-arithmetic rounding model
module tb_floating_point_add;
`ifdef FP_ADD_SUBNORMAL_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, a_v, b_v, rv;
  logic [15:0] a_d, b_d, rd, last;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  floating_point_add dut (
    .clk(clk), .rst(rst),
    .s_axis_a_tvalid(a_v), .s_axis_a_tdata(a_d),
    .s_axis_b_tvalid(b_v), .s_axis_b_tdata(b_d),
    .m_axis_result_tvalid(rv), .m_axis_result_tdata(rd)
  );
  function automatic real p2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction
  function automatic real val(input logic [15:0] x);
    real m;
    if (x[14:10] == 5'd0) m = SUB_EN ? real'(x[9:0]) * p2(-24) : 0.0;
    else m = (1024.0 + real'(x[9:0])) * p2(int'(x[14:10]) - 25);
    return x[15] ? -m : m;
  endfunction
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    bit an, bn, ai, bi, neg;
    real s, m, q, n, fl;
    int e;
    an = a[14:10] == 5'd31 && a[9:0] != 10'd0;
    bn = b[14:10] == 5'd31 && b[9:0] != 10'd0;
    ai = a[14:10] == 5'd31 && a[9:0] == 10'd0;
    bi = b[14:10] == 5'd31 && b[9:0] == 10'd0;
    if (an || bn || (ai && bi && a[15] != b[15])) return 16'h7E00;
    if (ai) return a;
    if (bi) return b;
    s = val(a) + val(b);
    if (s == 0.0) return {a[15] & b[15], 15'b0};
    neg = s < 0.0;
    m = neg ? -s : s;
    if (!SUB_EN && m < p2(-14)) return {neg, 15'b0};
    e = -14;
    while (m >= p2(e + 1)) e++;
    q = p2(e - 10);
    n = m / q;
    fl = $floor(n);
    if (n - fl > 0.5 || (n - fl == 0.5 && $rtoi(fl) % 2 == 1)) fl = fl + 1.0;
    m = fl * q;
    if (m >= 65536.0) return {neg, 15'h7C00};
    if (m < p2(-14)) return {neg, 5'd0, 10'($rtoi(m / p2(-24)))};
    e = -14;
    while (m >= p2(e + 1)) e++;
    return {neg, 5'(e + 15), 10'($rtoi(m / p2(e - 10)) - 1024)};
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic op(input logic [15:0] x, input logic [15:0] y, input logic [15:0] exp, input string tag);
    a_v = 1'b1;
    b_v = 1'b1;
    a_d = x;
    b_d = y;
    @(posedge clk);
    #1;
    chk({tag, " valid"}, {15'b0, rv}, 16'h0001);
    chk(tag, rd, exp);
    last = exp;
  endtask
  initial begin
    rst = 1'b1;
    a_v = 1'b0;
    b_v = 1'b0;
    a_d = 16'h1234;
    b_d = 16'h4321;
    last = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", {15'b0, rv}, 16'h0000);
    chk("reset data", rd, 16'h0000);
    rst = 1'b0;
    op(16'h3C00, 16'h3C00, 16'h4000, "1+1");
    op(16'h3C00, 16'hBC00, 16'h0000, "x-x");
    op(16'hBC00, 16'h3C00, 16'h0000, "-x+x");
    op(16'h8000, 16'h8000, 16'h8000, "-0+-0");
    op(16'h0000, 16'h8000, 16'h0000, "+0+-0");
    op(16'h8000, 16'h0000, 16'h0000, "-0++0");
    op(16'h7BFF, 16'h7BFF, 16'h7C00, "overflow");
    op(16'hFBFF, 16'hFBFF, 16'hFC00, "neg overflow");
    op(16'h7C00, 16'hFC00, 16'h7E00, "inf-inf");
    op(16'h7E01, 16'h3C00, 16'h7E00, "nan a");
    op(16'h3C00, 16'h7E01, 16'h7E00, "nan b");
    op(16'h7C00, 16'hBC00, 16'h7C00, "inf+fin");
    op(16'hFC00, 16'hFC00, 16'hFC00, "-inf+-inf");
    op(16'h3C00, 16'h1000, 16'h3C00, "tie even");
    op(16'h3C01, 16'h1000, 16'h3C02, "tie odd");
    op(16'h3C00, 16'h0401, 16'h3C00, "far sticky");
    op(16'h4000, 16'hBBFF, 16'h3C00, "renorm");
    op(16'h0001, 16'h0001, SUB_EN ? 16'h0002 : 16'h0000, "sub+sub");
    op(16'h0400, 16'h8001, SUB_EN ? 16'h03FF : 16'h0400, "min-sub");
    op(16'h0400, 16'h8401, SUB_EN ? 16'h8001 : 16'h8000, "underflow");
    op(16'h5555, 16'h2AAA, ref_add(16'h5555, 16'h2AAA), "pre-gap");
    a_v = 1'b0;
    a_d = 16'h3C00;
    @(posedge clk);
    #1;
    chk("gap valid", {15'b0, rv}, 16'h0000);
    chk("gap hold", rd, last);
    op(16'h4200, 16'hC000, 16'h3C00, "pre-rst");
    rst = 1'b1;
    a_v = 1'b1;
    b_v = 1'b1;
    a_d = 16'h3C00;
    b_d = 16'h3C00;
    @(posedge clk);
    #1;
    chk("rst valid", {15'b0, rv}, 16'h0000);
    chk("rst data", rd, 16'h0000);
    rst = 1'b0;
    op(16'h4400, 16'h4400, 16'h4800, "post-rst");
    for (int i = 0; i < 300; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0: y = 16'($urandom);
        1: y = {1'($urandom), x[14:10], 10'($urandom)};
        2: y = x ^ 16'h8000;
        default: begin
          x[14:10] = 5'($urandom_range(0, 2));
          y = {1'($urandom), 5'($urandom_range(0, 2)), 10'($urandom)};
        end
      endcase
      op(x, y, ref_add(x, y), "rand ab");
      op(y, x, ref_add(x, y), "rand ba");
    end
    a_v = 1'b0;
    b_v = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/floating_point_add.md
FLOATING_POINT_ADD -- requirements
Module: floating_point_add

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: s_axis_a_tvalid  input  1  operand A valid.
REQ-005 Port: s_axis_a_tdata  input  16  operand A, IEEE-754 binary16.
REQ-006 Port: s_axis_b_tvalid  input  1  operand B valid.
REQ-007 Port: s_axis_b_tdata  input  16  operand B, IEEE-754 binary16.
REQ-008 Port: m_axis_result_tvalid  output  1  result valid.
REQ-009 Port: m_axis_result_tdata  output  16  A+B, binary16.
REQ-010 No tready on any channel; the block SHALL never stall.

Function
REQ-011 The block SHALL accept an operation on a rising clk edge where both s_axis_a_tvalid and s_axis_b_tvalid are 1 and rst is 0.
REQ-012 Latency SHALL be exactly 1 cycle: result and tvalid=1 are registered on the accepting edge; throughput 1 operation/cycle.
REQ-013 On an edge with either input valid low, m_axis_result_tvalid SHALL go 0; m_axis_result_tdata SHALL hold its last value.
REQ-014 Sum SHALL be the exactly-rounded A+B, round-to-nearest-ties-to-even.
REQ-015 Alignment SHALL keep guard, round and sticky bits; sticky ORs all bits shifted beyond round; shift amounts >= 13 collapse the smaller operand into sticky.
REQ-016 Effective subtraction SHALL renormalize via leading-zero count; mantissa carry-out after rounding SHALL increment the exponent.
REQ-017 Exact cancellation (x + -x, finite) SHALL give +0 (0x0000); (-0)+(-0) SHALL give 0x8000; (+0)+(-0) SHALL give 0x0000.
REQ-018 Result exponent >= 31 after rounding SHALL give signed infinity (0x7C00/0xFC00).
REQ-019 Any NaN input, or +Inf plus -Inf, SHALL give canonical quiet NaN 0x7E00.
REQ-020 Inf plus finite SHALL give that Inf; Inf plus same-sign Inf SHALL give that Inf.
REQ-021 Operand order SHALL not affect the result (commutative, including sign of zero).

Reset
REQ-022 While rst=1 at a clk edge: m_axis_result_tvalid<=0, m_axis_result_tdata<=16'h0000, inputs ignored.
REQ-023 An operation accepted on the cycle before rst asserts SHALL still be visible for that one cycle; an operation presented on the rst edge SHALL be discarded.

Configuration
REQ-024 Macro FP_ADD_SUBNORMAL_EN defined: subnormal inputs are used at full value and subnormal results are produced with correct rounding (gradual underflow).
REQ-025 Macro FP_ADD_SUBNORMAL_EN undefined: subnormal inputs are treated as signed zero, and results below 2^-14 after rounding are flushed to zero with the exact-sum sign (+0 on exact cancellation).

Structure
REQ-026 Shared package fp_add_pkg SHALL hold: EXP_W=5, MAN_W=10, BIAS=15, EXP_MAX=31, QNAN=16'h7E00, POS_INF=16'h7C00, NEG_INF=16'hFC00, and a binary16 field struct (sign, exp, man).
REQ-027 One sub-module fp_lzc (leading-zero count over the 14-bit normalized sum) SHALL be used; all other logic stays in floating_point_add.

Verification
REQ-028 A=0x3C00, B=0x3C00, both valid -> next cycle tvalid=1, tdata=0x4000 (1+1=2).
REQ-029 A=0x3C00, B=0xBC00 -> 0x0000; A=0x8000, B=0x8000 -> 0x8000.
REQ-030 A=0x7BFF, B=0x7BFF -> 0x7C00; A=0x7C00, B=0xFC00 -> 0x7E00; A=0x7E01, B=0x3C00 -> 0x7E00.
REQ-031 A=0x3C00, B=0x1000 (2^-11, tie) -> 0x3C00; A=0x3C01, B=0x1000 -> 0x3C02 (ties-to-even).
REQ-032 A=0x0001, B=0x0001 -> 0x0002 with FP_ADD_SUBNORMAL_EN, 0x0000 without; A=0x0400, B=0x8001 -> 0x03FF with FP_ADD_SUBNORMAL_EN, 0x0400 without.
REQ-033 Back-to-back ops every cycle, one cycle with a_tvalid=0, then rst pulse mid-stream -> one result per valid cycle in order, tvalid=0 for the gap, and tvalid=0/tdata=0x0000 after the rst edge.
